// File: rtl/bcd_pkg.sv
// Shared state encoding and 7-segment constants for the sequential BCD display.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
endpackage

// File: rtl/seg7_decode.sv
// Single BCD digit to active-low 7-segment decode (a..g = bit 0..6); non-decimal codes blank.
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_ZERO;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_seq_display.sv
// Iterative double-dabble binary-to-BCD converter driving DIGITS 7-segment displays.
// Define BCD_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_seq_display
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  state_e                   r_state, w_next;
  logic [WIDTH-1:0]         r_sr;
  logic [BW-1:0]            r_work, w_adj;
  logic [CW-1:0]            r_cnt;
  logic                     r_acc, r_done, r_ovf;
  logic [BW-1:0]            r_bcd;
  logic [DIGITS-1:0][6:0]   w_seg;
  logic [DIGITS-1:0]        w_blank;

  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++)
      if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == CW'(1)) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sr   <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_acc  <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_bcd  <= '0;
    end else begin
      r_done <= (r_state == COMMIT);
      case (r_state)
        IDLE: if (start) begin
          r_sr   <= bin;
          r_work <= '0;
          r_cnt  <= CW'(WIDTH);
          r_acc  <= 1'b0;
        end
        SHIFT: begin
          // Any 1 leaving the top digit means the value needs more than DIGITS digits.
          r_work <= {w_adj[BW-2:0], r_sr[WIDTH-1]};
          r_sr   <= r_sr << 1;
          r_cnt  <= r_cnt - CW'(1);
          if (w_adj[BW-1]) r_acc <= 1'b1;
        end
        COMMIT: begin
          r_bcd <= r_work;
          r_ovf <= r_acc;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dec
      seg7_decode u_dec (.i_digit(r_bcd[4*gi +: 4]), .o_seg(w_seg[gi]));
    end
  endgenerate

  always_comb begin
    w_blank = '0;
`ifdef BCD_LZ_BLANK_EN
    begin
      logic v_seen;
      v_seen = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (r_bcd[4*i +: 4] != 4'd0) v_seen = 1'b1;
        w_blank[i] = !v_seen;
      end
    end
`endif
  end

  always_comb begin
    hex = '0;
    for (int i = 0; i < DIGITS; i++)
      hex[7*i +: 7] = r_ovf ? SEG_DASH : (w_blank[i] ? SEG_BLANK : w_seg[i]);
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign ovf  = r_ovf;
  assign bcd  = r_bcd;
endmodule

// File: tb/tb_bcd_seq_display.sv
// Directed bench for bcd_seq_display: 8b/3-digit, 8b/2-digit overflow and 1b/1-digit instances.
module tb_bcd_seq_display;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
  localparam logic [6:0] DA = 7'h3f;
`ifdef BCD_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7f;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a = '0;
  logic [11:0] bcd_a;
  logic [20:0] hex_a;
  logic        start_b = 1'b0, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b = '0;
  logic [7:0]  bcd_b;
  logic [13:0] hex_b;
  logic        start_c = 1'b0, busy_c, done_c, ovf_c;
  logic [0:0]  bin_c = '0;
  logic [3:0]  bcd_c;
  logic [6:0]  hex_c;

  bcd_seq_display #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .resetn(resetn), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .hex(hex_a));
  bcd_seq_display #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .resetn(resetn), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .hex(hex_b));
  bcd_seq_display #(.WIDTH(1), .DIGITS(1)) u_c (
    .clk(clk), .resetn(resetn), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .ovf(ovf_c), .bcd(bcd_c), .hex(hex_c));

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref3(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Starts a conversion on instance A and returns on its done cycle (bounded).
  task automatic conv_a(input logic [7:0] v);
    int n;
    bin_a = v; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 30) begin tick(); n++; end
    chk("a_done_timeout", 32'(done_a), 32'd1);
  endtask

  task automatic conv_b(input logic [7:0] v);
    int n;
    bin_b = v; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 30) begin tick(); n++; end
    chk("b_done_timeout", 32'(done_b), 32'd1);
  endtask

  initial begin
    int dcount, n;
    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_ovf",  32'(ovf_a), 0);
    chk("rst_bcd",  32'(bcd_a), 0);
    chk("rst_hex",  32'(hex_a), 32'({LZ, LZ, S0}));
    resetn = 1'b1;
    tick();

    // 255: exact busy/done timing, bin changes after capture ignored
    bin_a = 8'd255; start_a = 1'b1;
    tick();
    start_a = 1'b0; bin_a = 8'd17;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("t255_busy_k%0d", k), 32'(busy_a), 32'(k <= 9));
      chk($sformatf("t255_done_k%0d", k), 32'(done_a), 32'(k == 10));
      if (k == 5) chk("t255_bcd_held", 32'(bcd_a), 32'h000);
      if (k < 10) tick();
    end
    chk("t255_bcd", 32'(bcd_a), 32'h255);
    chk("t255_ovf", 32'(ovf_a), 0);
    chk("t255_hex", 32'(hex_a), 32'({S2, S5, S5}));
    tick();
    chk("t255_done_width", 32'(done_a), 0);

    // 0, with held-result check mid-conversion
    bin_a = 8'd0; start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick();
    chk("t0_bcd_held", 32'(bcd_a), 32'h255);
    n = 0;
    while (!done_a && n < 30) begin tick(); n++; end
    chk("t0_bcd", 32'(bcd_a), 32'h000);
    chk("t0_hex", 32'(hex_a), 32'({LZ, LZ, S0}));

    conv_a(8'd105);
    chk("t105_bcd", 32'(bcd_a), 32'h105);
    chk("t105_hex", 32'(hex_a), 32'({S1, S0, S5}));
    conv_a(8'd7);
    chk("t7_hex", 32'(hex_a), 32'({LZ, LZ, S7}));
    conv_a(8'd68);
    chk("t68_bcd", 32'(bcd_a), 32'h068);
    chk("t68_hex", 32'(hex_a), 32'({LZ, S6, S8}));
    conv_a(8'd42);
    chk("t42a_hex", 32'(hex_a), 32'({LZ, S4, S2}));

    // Start during busy is ignored
    tick();
    bin_a = 8'd9; start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick();
    bin_a = 8'd200; start_a = 1'b1;
    tick(); start_a = 1'b0;
    dcount = 0;
    repeat (20) begin
      if (done_a) dcount++;
      tick();
    end
    chk("ign_done_count", 32'(dcount), 1);
    chk("ign_bcd", 32'(bcd_a), 32'h009);
    chk("ign_hex", 32'(hex_a), 32'({LZ, LZ, S9}));

    // Reset mid-conversion of 123
    bin_a = 8'd123; start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_busy_pre", 32'(busy_a), 1);
    resetn = 1'b0;
    #1;
    chk("rstmid_bcd", 32'(bcd_a), 0);
    chk("rstmid_busy", 32'(busy_a), 0);
    chk("rstmid_done", 32'(done_a), 0);
    dcount = 0;
    repeat (3) begin tick(); if (done_a) dcount++; end
    resetn = 1'b1;
    repeat (12) begin tick(); if (done_a) dcount++; end
    chk("rstmid_no_done", 32'(dcount), 0);
    chk("rstmid_busy_after", 32'(busy_a), 0);
    conv_a(8'd123);
    chk("t123_bcd", 32'(bcd_a), 32'h123);
    chk("t123_hex", 32'(hex_a), 32'({S1, S2, S3}));

    // Two-digit instance: overflow then recovery
    conv_b(8'd100);
    chk("b100_ovf", 32'(ovf_b), 1);
    chk("b100_hex", 32'(hex_b), 32'({DA, DA}));
    conv_b(8'd42);
    chk("b42_bcd", 32'(bcd_b), 32'h42);
    chk("b42_ovf", 32'(ovf_b), 0);
    chk("b42_hex", 32'(hex_b), 32'({S4, S2}));

    // WIDTH=1: single shift cycle, done at T+3
    bin_c = 1'b1; start_c = 1'b1;
    tick(); start_c = 1'b0;
    chk("c_busy_t1", 32'(busy_c), 1);
    tick();
    chk("c_busy_t2", 32'(busy_c), 1);
    chk("c_done_t2", 32'(done_c), 0);
    tick();
    chk("c_done_t3", 32'(done_c), 1);
    chk("c_busy_t3", 32'(busy_c), 0);
    chk("c_bcd", 32'(bcd_c), 32'h1);
    chk("c_hex", 32'(hex_c), 32'(S1));

    // Back-to-back sweep, each start issued on the done cycle
    tick();
    bin_a = 8'd0; start_a = 1'b1;
    tick(); start_a = 1'b0;
    for (int v = 0; v < 256; v++) begin
      n = 0;
      while (!done_a && n < 20) begin tick(); n++; end
      chk($sformatf("sw_done_v%0d", v), 32'(done_a), 1);
      chk($sformatf("sw_bcd_v%0d", v), 32'(bcd_a), 32'(ref3(v)));
      if (v < 255) begin bin_a = 8'(v + 1); start_a = 1'b1; end
      tick();
      start_a = 1'b0;
      chk($sformatf("sw_width_v%0d", v), 32'(done_a), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_seq_display.md
# bcd_seq_display

Sequential, parametrised binary-to-BCD converter with multi-digit 7-segment output. It extends the single-digit-pair combinational display path to any WIDTH-bit unsigned input and DIGITS decimal digits. Conversion uses an iterative shift-add-3 (double-dabble) algorithm under a start/done handshake. It sits between a binary datapath (counter, ALU result, switch bank) and the board's HEX displays.

## Interface
- WIDTH, 8: binary input width; must be ≥ 1.
- DIGITS, 3: number of BCD digits and HEX displays driven; must be ≥ 1.

- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of `bin`; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is committed.
- ovf  output  1  result exceeds 10^DIGITS−1; held with the result.
- bcd  output  4*DIGITS  committed result, digit i at [4i+3:4i].
- hex  output  7*DIGITS  active-low segments, display i at [7i+6:7i], segment order a..g = bit 0..6.

## Operation
- The FSM has three states:
  - IDLE: waits for start. On start=1, loads shift register ← bin, working BCD ← 0, counter ← WIDTH, overflow accumulator ← 0, then goes to SHIFT.
  - SHIFT: each cycle, adds 3 to every working digit ≥ 5, then shifts {working BCD, shift reg} left by one. Decrements the counter. When the counter reaches 1, goes to COMMIT.
  - COMMIT: copies working BCD to `bcd` and the accumulator to `ovf`, pulses done, then returns to IDLE.
- Overflow: if the bit shifted out of the top BCD digit is ever 1, the accumulator sets.
- Output registers `bcd` and `ovf` change only in COMMIT; they hold the previous result during conversion, so displays never flicker.
- `hex` is a combinational decode of the registered `bcd`/`ovf`:
  - ovf=1: every display shows a dash (7'b0111111).
  - Otherwise each digit 0–9 uses the standard decode. Codes 10–15 cannot occur; they decode to blank (7'b1111111).
- start while busy is ignored; there is no queuing.
- `bin` changes after capture do not affect the running conversion.

## Timing
- Start accepted in cycle T (IDLE, start=1).
- busy is high in cycles T+1 .. T+WIDTH+1.
- done=1 and the new `bcd` are visible in cycle T+WIDTH+2. The total latency is WIDTH+2 cycles.
- The next start is accepted no earlier than cycle T+WIDTH+2, when the FSM is back in IDLE.
- Reset values: state=IDLE, busy=0, done=0, ovf=0, bcd=0. hex therefore shows "0" on every display (7'b1000000), subject to the configuration macro.
- Reset asserted mid-conversion aborts immediately to the reset values; no done pulse is produced.
- The counter width is $clog2(WIDTH+1).
- WIDTH=1 is legal: one SHIFT cycle.

## Configuration
- BCD_LZ_BLANK_EN defined: leading-zero blanking.
  - Every digit above the most significant non-zero digit is blank (7'b1111111).
  - Digit 0 is always displayed, so a value of 0 shows a single "0".
  - Blanking does not apply when ovf=1.
  - Reset display: digit 0 shows "0" and the rest are blank.
- Undefined: all DIGITS displays are always shown, including leading zeros.
- The `bcd` output is identical in both cases.

## Structure
- Package bcd_pkg holds:
  - the state enum {IDLE, SHIFT, COMMIT};
  - the constants SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111 and SEG_ZERO=7'b1000000.
- Sub-module seg7_decode: 4-bit digit in, 7-bit active-low segments out, with blank for codes 10–15. It is instantiated DIGITS times in a generate loop. Blanking and ovf overrides are applied outside the sub-module.

## Test plan
- WIDTH=8, DIGITS=3, bin=255, start pulse → bcd=12'h255, ovf=0, done exactly at T+10, busy high for 9 cycles.
- bin=0 → bcd=12'h000. Without the macro, hex = {SEG_ZERO, SEG_ZERO, SEG_ZERO}. With BCD_LZ_BLANK_EN, hex = {SEG_BLANK, SEG_BLANK, SEG_ZERO}.
- DIGITS=2, bin=100 → ovf=1, all displays SEG_DASH. A following conversion of bin=42 → bcd=8'h42, ovf=0.
- Start bin=9 and then, during busy, start with bin=200 → a single done, bcd=12'h009; the second start is ignored.
- resetn low at T+4 of a conversion of bin=123 → bcd=0, busy=0, no done. After release, a conversion of bin=123 gives bcd=12'h123.
- Sweep bin=0..255 back-to-back, with each start issued on the done cycle → every bcd matches the decimal reference and every done pulse is one cycle wide.
